param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, number of stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port push  input  1  push request, sampled on rising clk.
REQ-006 SHALL have port pop  input  1  pop request, sampled on rising clk.
REQ-007 SHALL have port din  input  WIDTH  word to push.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port dout  output  WIDTH  registered word returned by last accepted pop.
REQ-010 SHALL have port ack  output  1  one-cycle pulse, previous cycle's request accepted.
REQ-011 SHALL have port top  output  WIDTH  combinational peek of top entry, 0 when empty.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0, both combinational from count.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL perform every operation in one cycle; count, top, full and empty reflect it from the next cycle; ack asserts that next cycle only.
REQ-016 Push only, not full: SHALL write din to entry count, increment count; dout unchanged.
REQ-017 Pop only, not empty: SHALL load dout with entry count-1, decrement count.
REQ-018 Push and pop, not empty (including full): SHALL load dout with old top, overwrite top entry with din, count unchanged, no error.
REQ-019 Push and pop, empty: SHALL pass through, dout<=din, count stays 0, no error, ack asserted.
REQ-020 Push only, full: SHALL reject, memory/count/dout unchanged, set overflow, ack low.
REQ-021 Pop only, empty: SHALL reject, count/dout unchanged, set underflow, ack low.
REQ-022 Neither push nor pop: SHALL hold all state, ack low.
REQ-023 overflow/underflow SHALL stay set until clr_err; if clr_err and a new error of the same kind occur in one cycle, the flag SHALL be set.
REQ-024 count SHALL never exceed DEPTH nor go below 0; no wrap-around of the pointer.
REQ-025 Memory SHALL be a DEPTH x WIDTH register array, written only by accepted push (REQ-016/018).

Reset
REQ-026 rst high at a rising edge SHALL force count=0, dout=0, ack=0, overflow=0, underflow=0, overriding push/pop/clr_err that cycle.
REQ-027 Memory contents need not be cleared; top SHALL read 0 after reset because empty=1.
REQ-028 Reset asserted mid-sequence SHALL discard the stack; first operation after rst release behaves as on an empty stack.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles -> ack high 4 cycles, count=4, full=1, top=0x44.
REQ-030 From full, push 0x55 -> ack low, overflow=1, count=4, top=0x44; clr_err pulse -> overflow=0.
REQ-031 From full, pop x4 -> dout sequence 0x44,0x33,0x22,0x11, empty=1, top=0; fifth pop -> underflow=1, dout stays 0x11, ack low.
REQ-032 Stack holding 0xA0,0xB0: push+pop with din=0xC0 -> dout=0xB0, top=0xC0, count=2; on empty stack push+pop din=0x7E -> dout=0x7E, count=0, no error.
REQ-033 Push 0x01,0x02, assert rst one cycle with push=1 -> count=0, dout=0, empty=1; then pop -> underflow=1.
REQ-034 Underflow set and clr_err asserted together with another empty pop -> underflow remains 1.

Source files
------------

// File: rtl/param_stack.sv
// param_stack: single-clock LIFO of DEPTH x WIDTH registers.
// Supports push, pop, simultaneous push+pop (swap or pass-through),
// a combinational top-of-stack peek and sticky overflow/underflow flags.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     ack,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;
  logic             do_pass;
  logic             ovf_ev;
  logic             unf_ev;
  logic             accept;
  logic             dout_ld;
  logic [WIDTH-1:0] dout_nxt;
  logic [CW-1:0]    count_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Free slot sits at count; top entry at count-1. When full, the low
  // AW bits of count are zero, so count-1 wraps to DEPTH-1 as intended.
  assign wr_idx  = count[AW-1:0];
  assign top_idx = count[AW-1:0] - ONE_IDX;
  assign top     = empty ? '0 : mem[top_idx];

  // Decode the request against the current fill level.
  always_comb begin
    do_push   = push & ~pop & ~full;
    do_pop    = pop & ~push & ~empty;
    do_swap   = push & pop & ~empty;
    do_pass   = push & pop & empty;
    ovf_ev    = push & ~pop & full;
    unf_ev    = pop & ~push & empty;
    accept    = do_push | do_pop | do_swap | do_pass;
    dout_ld   = do_pop | do_swap | do_pass;
    dout_nxt  = do_pass ? din : mem[top_idx];
    count_nxt = count;
    if (do_push)     count_nxt = count + ONE_CNT;
    else if (do_pop) count_nxt = count - ONE_CNT;
  end

  // Storage array: written only by an accepted push or swap, never reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push)      mem[wr_idx]  <= din;
      else if (do_swap) mem[top_idx] <= din;
    end
  end

  // Control state, returned word, handshake pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      dout      <= '0;
      ack       <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      ack       <= accept;
      if (dout_ld) dout <= dout_nxt;
      overflow  <= ovf_ev | (overflow & ~clr_err);
      underflow <= unf_ev | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed scenarios plus randomized traffic for param_stack
// (WIDTH=8, DEPTH=4), compared each cycle against a queue-based LIFO model.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             ack;
  logic [WIDTH-1:0] top;
  logic [$clog2(DEPTH):0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .ack(ack), .top(top), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ack = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LIFO semantics in terms of the queue: back of queue is top of stack.
  task automatic model_update(input logic p, input logic po, input logic [WIDTH-1:0] d,
                              input logic c, input logic r);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (p && !po) begin
        if (q.size() < DEPTH) begin q.push_back(d); m_ack = 1'b1; end
        else oe = 1'b1;
      end else if (po && !p) begin
        if (q.size() > 0) begin m_dout = q.pop_back(); m_ack = 1'b1; end
        else ue = 1'b1;
      end else if (p && po) begin
        if (q.size() == 0) m_dout = d;
        else begin m_dout = q[q.size()-1]; q[q.size()-1] = d; end
        m_ack = 1'b1;
      end
      m_ovf = oe | (m_ovf & ~c);
      m_unf = ue | (m_unf & ~c);
    end
  endtask

  task automatic compare_model();
    chk("dout", dout, m_dout);
    chk("ack", ack, m_ack);
    chk("count", count, q.size());
    chk("top", top, (q.size() > 0) ? q[q.size()-1] : 0);
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check outputs.
  task automatic step(input logic p, input logic po, input logic [WIDTH-1:0] d,
                      input logic c, input logic r);
    @(negedge clk);
    push = p; pop = po; din = d; clr_err = c; rst = r;
    @(posedge clk);
    model_update(p, po, d, c, r);
    #1;
    compare_model();
  endtask

  initial begin
    logic p, po, c, r;
    logic [WIDTH-1:0] d;

    // Reset
    step(0, 0, 8'h00, 0, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_top", top, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("idle_ack", ack, 0);

    // Fill to full
    step(1, 0, 8'h11, 0, 0); chk("p1_ack", ack, 1);
    step(1, 0, 8'h22, 0, 0); chk("p2_ack", ack, 1);
    step(1, 0, 8'h33, 0, 0); chk("p3_ack", ack, 1);
    step(1, 0, 8'h44, 0, 0); chk("p4_ack", ack, 1);
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_top", top, 8'h44);

    // Overflow and clear
    step(1, 0, 8'h55, 0, 0);
    chk("ovf_ack", ack, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_top", top, 8'h44);
    step(0, 0, 8'h00, 1, 0);
    chk("ovf_clr", overflow, 0);

    // Drain and underflow
    step(0, 1, 8'h00, 0, 0); chk("pop1", dout, 8'h44);
    step(0, 1, 8'h00, 0, 0); chk("pop2", dout, 8'h33);
    step(0, 1, 8'h00, 0, 0); chk("pop3", dout, 8'h22);
    step(0, 1, 8'h00, 0, 0); chk("pop4", dout, 8'h11);
    chk("drain_empty", empty, 1);
    chk("drain_top", top, 0);
    step(0, 1, 8'h00, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_dout", dout, 8'h11);
    chk("unf_ack", ack, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("unf_clr", underflow, 0);

    // Swap on a non-empty stack, pass-through on an empty one
    step(1, 0, 8'hA0, 0, 0);
    step(1, 0, 8'hB0, 0, 0);
    step(1, 1, 8'hC0, 0, 0);
    chk("swap_dout", dout, 8'hB0);
    chk("swap_top", top, 8'hC0);
    chk("swap_count", count, 2);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0); chk("swap_under", dout, 8'hA0);
    step(1, 1, 8'h7E, 0, 0);
    chk("pass_dout", dout, 8'h7E);
    chk("pass_count", count, 0);
    chk("pass_ack", ack, 1);
    chk("pass_err", {overflow, underflow}, 0);

    // Swap while full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i + 1), 0, 0);
    step(1, 1, 8'hEE, 0, 0);
    chk("fswap_dout", dout, 8'h04);
    chk("fswap_top", top, 8'hEE);
    chk("fswap_ovf", overflow, 0);

    // Reset mid-sequence overrides a push
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'h01, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(1, 0, 8'h03, 0, 1);
    chk("mrst_count", count, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_empty", empty, 1);
    step(0, 1, 8'h00, 0, 0);
    chk("mrst_unf", underflow, 1);

    // New underflow wins over clr_err in the same cycle
    step(0, 1, 8'h00, 1, 0);
    chk("unf_sticky", underflow, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      c  = ($urandom_range(0, 99) < 10);
      r  = ($urandom_range(0, 99) < 2);
      d  = 8'($urandom());
      step(p, po, d, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
